trng_harvest_ctrl: RTL and testbench

Sequencing and health-check stage directly downstream of the ring-oscillator TRNG. It re-arms the TRNG source, launches a collection run, captures the 128-bit word on `done`, and rejects stuck or repeated words with bounded retry. Accepted words go to the consumer (key/nonce logic) over a valid/ready handshake. Persistent failure raises a sticky error.

---
 rtl/trng_harvest_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_trng_harvest_ctrl.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_harvest_ctrl.sv
// trng_harvest_ctrl: sequences the ring-oscillator TRNG, health-checks each
// 128-bit word (stuck / repeat / timeout) with bounded retry and hands
// accepted words to the consumer over a valid/ready handshake.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   req         request one word (sampled only when idle)
//   trng_rst    active-high synchronous reset to the source
//   trng_go     one-cycle start pulse to the source
//   trng_done   source completion (sticky until trng_rst)
//   trng_data   source word, stable while trng_done is high
//   rand_valid  rand_data holds an accepted word
//   rand_ready  consumer accepts the word
//   rand_data   accepted random word
//   busy        a request is in flight
//   err         sticky health failure
//   err_code    cause of the last failed attempt
//               (0 none, 1 stuck, 2 repeat, 3 timeout)
module trng_harvest_ctrl #(
    parameter int W          = 128,
    parameter int TIMEOUT    = 1023,
    parameter int MAX_RETRY  = 3,
    parameter int REPEAT_CHK = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    output logic         trng_rst,
    output logic         trng_go,
    input  logic         trng_done,
    input  logic [W-1:0] trng_data,
    output logic         rand_valid,
    input  logic         rand_ready,
    output logic [W-1:0] rand_data,
    output logic         busy,
    output logic         err,
    output logic [1:0]   err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GO,
        S_WAIT,
        S_CHECK,
        S_OUT,
        S_FAIL
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    localparam logic [1:0] C_NONE    = 2'd0;
    localparam logic [1:0] C_STUCK   = 2'd1;
    localparam logic [1:0] C_REPEAT  = 2'd2;
    localparam logic [1:0] C_TIMEOUT = 2'd3;

    state_t        state_q, state_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          to_q, to_d;
    logic [W-1:0]  cand_q, cand_d;
    logic [W-1:0]  prev_q, prev_d;
    logic          prev_valid_q, prev_valid_d;
    logic [W-1:0]  rand_data_q, rand_data_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          trng_rst_q, trng_rst_d;
    logic          trng_go_q, trng_go_d;
    logic          rand_valid_q, rand_valid_d;
    logic          busy_q, busy_d;

    logic [1:0]    cause;

    // Health classification of the captured candidate, in priority order.
    // A timed-out attempt never captured, so the stale candidate is ignored.
    always_comb begin
        cause = C_NONE;
        if (to_q) begin
            cause = C_TIMEOUT;
        end else if (cand_q == '0 || cand_q == '1) begin
            cause = C_STUCK;
        end else if (REPEAT_CHK != 0 && prev_valid_q
                     && cand_q == prev_q) begin
            cause = C_REPEAT;
        end
    end

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        retry_d      = retry_q;
        to_d         = to_q;
        cand_d       = cand_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        rand_data_d  = rand_data_q;
        err_d        = err_q;
        err_code_d   = err_code_q;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_GO;
                    retry_d = '0;
                end
            end
            S_GO: begin
                state_d = S_WAIT;
                wcnt_d  = '0;
                to_d    = 1'b0;
            end
            S_WAIT: begin
                if (trng_done) begin
                    cand_d  = trng_data;
                    state_d = S_CHECK;
                end else if (wcnt_q == WAIT_LAST) begin
                    to_d    = 1'b1;
                    state_d = S_CHECK;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (cause == C_NONE) begin
                    prev_d       = cand_q;
                    prev_valid_d = 1'b1;
                    rand_data_d  = cand_q;
                    state_d      = S_OUT;
                end else if (retry_q < RETRY_MAX) begin
                    retry_d    = retry_q + 1'b1;
                    err_code_d = cause;
                    state_d    = S_GO;
                end else begin
                    err_d      = 1'b1;
                    err_code_d = cause;
                    state_d    = S_FAIL;
                end
            end
            S_OUT: begin
                if (rand_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered: decode them from the next state so they
        // line up with the state they describe.
        trng_go_d    = (state_d == S_GO);
        trng_rst_d   = !(state_d == S_GO || state_d == S_WAIT);
        rand_valid_d = (state_d == S_OUT);
        busy_d       = !(state_d == S_IDLE || state_d == S_FAIL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            wcnt_q       <= '0;
            retry_q      <= '0;
            to_q         <= 1'b0;
            cand_q       <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            rand_data_q  <= '0;
            err_q        <= 1'b0;
            err_code_q   <= C_NONE;
            trng_rst_q   <= 1'b1;
            trng_go_q    <= 1'b0;
            rand_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            retry_q      <= retry_d;
            to_q         <= to_d;
            cand_q       <= cand_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            rand_data_q  <= rand_data_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            trng_rst_q   <= trng_rst_d;
            trng_go_q    <= trng_go_d;
            rand_valid_q <= rand_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign trng_rst   = trng_rst_q;
    assign trng_go    = trng_go_q;
    assign rand_valid = rand_valid_q;
    assign rand_data  = rand_data_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_trng_harvest_ctrl.sv
// Bench for trng_harvest_ctrl: behavioural TRNG source plus an
// attempt-level reference model of the health check and retry policy.
module tb_trng_harvest_ctrl;

    localparam int W         = 128;
    localparam int TIMEOUT   = 1023;
    localparam int MAX_RETRY = 3;

    logic         clk;
    logic         rst;
    logic         req;
    logic         trng_rst;
    logic         trng_go;
    logic         trng_done;
    logic [W-1:0] trng_data;
    logic         rand_valid;
    logic         rand_ready;
    logic [W-1:0] rand_data;
    logic         busy;
    logic         err;
    logic [1:0]   err_code;

    trng_harvest_ctrl #(
        .W(W), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .REPEAT_CHK(1)
    ) dut (
        .clk(clk), .rst(rst), .req(req),
        .trng_rst(trng_rst), .trng_go(trng_go),
        .trng_done(trng_done), .trng_data(trng_data),
        .rand_valid(rand_valid), .rand_ready(rand_ready),
        .rand_data(rand_data), .busy(busy),
        .err(err), .err_code(err_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // ring of per-attempt source behaviour, written by tests, read by source
    logic [W-1:0] ring_w [64];
    bit           ring_to[64];
    int           ring_wr = 0;
    int           ring_rd = 0;
    int           src_delay = 202;
    int           go_cnt = 0;

    // reference model state
    logic [W-1:0] ref_prev = '0;
    bit           ref_pv   = 0;
    bit           ref_err  = 0;
    logic [1:0]   ref_code = 2'd0;

    // scenario plan: behaviour of each attempt of the next request
    logic [W-1:0] plan_w [4];
    bit           plan_to[4];

    function automatic logic [W-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Source model: armed by go, asserts sticky done after src_delay
    // cycles (or never on a timeout attempt), cleared by trng_rst.
    initial begin
        bit armed;
        bit cur_to;
        int scnt;
        armed = 0;
        cur_to = 0;
        scnt = 0;
        trng_done = 1'b0;
        trng_data = '0;
        forever begin
            @(negedge clk);
            if (trng_go === 1'b1) go_cnt++;
            if (trng_rst !== 1'b0) begin
                trng_done = 1'b0;
                armed = 0;
            end else if (trng_go === 1'b1) begin
                armed = 1;
                scnt = 0;
                if (ring_rd != ring_wr) begin
                    trng_data = ring_w[ring_rd % 64];
                    cur_to = ring_to[ring_rd % 64];
                    ring_rd++;
                end else begin
                    trng_data = rand_word();
                    cur_to = 0;
                end
            end else if (armed && !trng_done && !cur_to) begin
                scnt++;
                if (scnt >= src_delay) trng_done = 1'b1;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req = 1'b0;
        rand_ready = 1'b0;
        ref_prev = '0;
        ref_pv = 0;
        ref_err = 0;
        ref_code = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // One request following plan_w/plan_to; the model decides which
    // attempt passes (if any), then the DUT is checked against it.
    task automatic run_req(input string nm, input int hold);
        int exp_att;
        bit exp_pass;
        logic [W-1:0] exp_word;
        logic [1:0] exp_code;
        logic [1:0] c;
        int go0;
        int budget;
        int k;
        bit seen;

        exp_att = 0;
        exp_pass = 0;
        exp_word = '0;
        exp_code = ref_code;
        for (int i = 0; i <= MAX_RETRY; i++) begin
            exp_att = i + 1;
            if (plan_to[i]) c = 2'd3;
            else if (plan_w[i] == '0 || plan_w[i] == '1) c = 2'd1;
            else if (ref_pv && plan_w[i] == ref_prev) c = 2'd2;
            else c = 2'd0;
            if (c == 2'd0) begin
                exp_pass = 1;
                exp_word = plan_w[i];
                break;
            end
            exp_code = c;
        end
        for (int i = 0; i < exp_att; i++) begin
            ring_w[ring_wr % 64] = plan_w[i];
            ring_to[ring_wr % 64] = plan_to[i];
            ring_wr++;
        end
        if (exp_pass) begin
            ref_prev = exp_word;
            ref_pv = 1;
        end else begin
            ref_err = 1;
        end
        ref_code = exp_code;

        go0 = go_cnt;
        budget = exp_att * (TIMEOUT + src_delay + 10) + 20;
        @(negedge clk);
        req = 1'b1;
        k = 0;
        seen = 0;
        while (k < budget && !seen) begin
            @(posedge clk);
            #1;
            req = 1'b0;
            k++;
            if (exp_pass ? rand_valid : (err && !busy)) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s no_completion: waited %0d cycles, valid=%b err=%b",
                     nm, k, rand_valid, err);
            return;
        end

        n_checks++;
        if (go_cnt - go0 != exp_att) begin
            n_fail++;
            $display("FAIL %s go_pulses: got %0d want %0d",
                     nm, go_cnt - go0, exp_att);
        end
        n_checks++;
        if (err_code !== ref_code || err !== ref_err) begin
            n_fail++;
            $display("FAIL %s err: got err=%b code=%0d want err=%b code=%0d",
                     nm, err, err_code, ref_err, ref_code);
        end

        if (exp_pass) begin
            if (exp_att == 1) begin
                n_checks++;
                if (k != src_delay + 3) begin
                    n_fail++;
                    $display("FAIL %s latency: got %0d want %0d",
                             nm, k, src_delay + 3);
                end
            end
            n_checks++;
            if (rand_data !== exp_word || busy !== 1'b1
                || trng_rst !== 1'b1) begin
                n_fail++;
                $display("FAIL %s data: got %h busy=%b trst=%b want %h busy=1 trst=1",
                         nm, rand_data, busy, trng_rst, exp_word);
            end
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                n_checks++;
                if (rand_valid !== 1'b1 || rand_data !== exp_word
                    || trng_rst !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s hold%0d: valid=%b data=%h trst=%b want 1 %h 1",
                             nm, h, rand_valid, rand_data, trng_rst, exp_word);
                end
            end
            @(negedge clk);
            rand_ready = 1'b1;
            @(posedge clk);
            #1;
            n_checks++;
            if (rand_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s handshake: valid=%b busy=%b want 0 0",
                         nm, rand_valid, busy);
            end
            @(negedge clk);
            rand_ready = 1'b0;
        end else begin
            n_checks++;
            if (k != exp_att * 0 + k) begin
                n_fail++;
            end
            n_checks++;
            if (rand_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s fail_valid: got %b want 0", nm, rand_valid);
            end
            go0 = go_cnt;
            @(negedge clk);
            req = 1'b1;
            @(negedge clk);
            req = 1'b0;
            repeat (20) @(negedge clk);
            n_checks++;
            if (go_cnt != go0 || err !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s fail_sticky: go+%0d err=%b busy=%b want go+0 err=1 busy=0",
                         nm, go_cnt - go0, err, busy);
            end
        end
    endtask

    task automatic check_reset_vals(input string nm);
        n_checks++;
        if (trng_rst !== 1'b1 || trng_go !== 1'b0 || rand_valid !== 1'b0
            || busy !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ctl: trst=%b go=%b valid=%b busy=%b err=%b want 1 0 0 0 0",
                     nm, trng_rst, trng_go, rand_valid, busy, err);
        end
        n_checks++;
        if (err_code !== 2'd0 || rand_data !== '0) begin
            n_fail++;
            $display("FAIL %s data: code=%0d data=%h want 0 0",
                     nm, err_code, rand_data);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 1'b0;
        rand_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("reset_async");
        repeat (3) @(negedge clk);
        check_reset_vals("reset_hold");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset_idle");
    endtask

    task automatic test_nominal();
        src_delay = 202;
        plan_w[0] = 128'h3dd16a0a3554db070e0b00ce143b7344;
        plan_to[0] = 0;
        run_req("nominal", 0);
    endtask

    task automatic test_backpressure();
        src_delay = 1 + $urandom_range(0, 40);
        plan_w[0] = rand_word();
        plan_to[0] = 0;
        run_req("backpressure", 10);
    endtask

    task automatic test_stuck();
        src_delay = 17;
        plan_w[0] = '0;
        plan_w[1] = '1;
        plan_w[2] = {16{8'hA5}};
        for (int i = 0; i < 3; i++) plan_to[i] = 0;
        run_req("stuck", 0);
    endtask

    task automatic test_repeat();
        src_delay = 9;
        plan_w[0] = ref_prev;
        plan_w[1] = ref_prev;
        plan_w[2] = 128'h1;
        for (int i = 0; i < 3; i++) plan_to[i] = 0;
        run_req("repeat_recover", 0);
        for (int i = 0; i < 4; i++) begin
            plan_w[i] = ref_prev;
            plan_to[i] = 0;
        end
        run_req("repeat_fail", 0);
        do_reset();
    endtask

    task automatic test_timeout();
        int t0;
        int len;
        src_delay = 5;
        for (int i = 0; i < 4; i++) begin
            plan_w[i] = rand_word();
            plan_to[i] = 1;
        end
        t0 = $time;
        run_req("timeout", 0);
        do_reset();
        len = 0;
        if (t0 >= 0) len = 1;
        n_checks++;
        if (len != 1) n_fail++;
    endtask

    task automatic test_async_reset();
        logic [W-1:0] wx;
        int k;
        src_delay = 100;
        ring_w[ring_wr % 64] = rand_word();
        ring_to[ring_wr % 64] = 0;
        ring_wr++;
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (50) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_reset_vals("areset_wait");
        @(negedge clk);
        rst = 1'b1;
        ref_prev = '0;
        ref_pv = 0;
        ref_err = 0;
        ref_code = 2'd0;
        repeat (2) @(negedge clk);

        src_delay = 12;
        wx = rand_word();
        ring_w[ring_wr % 64] = wx;
        ring_to[ring_wr % 64] = 0;
        ring_wr++;
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        k = 0;
        while (k < 200 && rand_valid !== 1'b1) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_checks++;
        if (rand_valid !== 1'b1 || rand_data !== wx) begin
            n_fail++;
            $display("FAIL areset_pre_out: valid=%b data=%h want 1 %h",
                     rand_valid, rand_data, wx);
        end
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("areset_out");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        // prev_valid was cleared, so the same word must pass again
        plan_w[0] = wx;
        plan_to[0] = 0;
        run_req("areset_after", 0);
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 12; n++) begin
            src_delay = 1 + $urandom_range(0, 60);
            for (int i = 0; i < 4; i++) begin
                r = $urandom_range(0, 9);
                if (r == 0) plan_w[i] = '0;
                else if (r == 1) plan_w[i] = '1;
                else if (r <= 3) plan_w[i] = ref_prev;
                else plan_w[i] = rand_word();
                plan_to[i] = ($urandom_range(0, 15) == 0);
            end
            run_req($sformatf("random%0d", n), $urandom_range(0, 3));
            if (ref_err) do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_stuck();
        test_repeat();
        test_timeout();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
